// File: rtl/bsg_manycore_reset_seq_pkg.sv
// bsg_manycore_reset_seq_pkg: shared state encoding and sizing helper for the tile reset sequencer.
// No ports; imported by bsg_manycore_tile_reset_seq.
package bsg_manycore_reset_seq_pkg;
   localparam int state_width_lp = 3;
   typedef enum logic [state_width_lp-1:0] {
      HOLD        = 3'd0,
      RTR_UP      = 3'd1,
      RUN         = 3'd2,
      DRAIN       = 3'd3,
      SOFT_RST    = 3'd4,
      SOFT_SETTLE = 3'd5
   } state_e;
   function automatic int safe_clog2(input int x);
      return (x <= 1) ? 1 : $clog2(x);
   endfunction
endpackage

// File: rtl/bsg_counter_clear_up.sv
// bsg_counter_clear_up: saturating up-counter with synchronous clear.
// Ports: clk_i clock, reset_i async active-high reset, clear_i zero the count,
//        up_i increment enable, count_o current count (holds at all-ones).
module bsg_counter_clear_up #(
   parameter int width_p = 8
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               clear_i,
   input  logic               up_i,
   output logic [width_p-1:0] count_o
);
   always_ff @(posedge clk_i or posedge reset_i)
      if (reset_i) count_o <= '0;
      else if (clear_i) count_o <= '0;
      else if (up_i && count_o != '1) count_o <= count_o + 1'b1;
endmodule

// File: rtl/bsg_manycore_tile_reset_seq.sv
// bsg_manycore_tile_reset_seq: per-tile reset sequencer; releases router before processor and services processor-only soft resets.
// Ports: clk_i tile clock, reset_i async active-high reset, soft_reset_req_i processor reset request (RUN only),
//        link_idle_i processor link drained, router_reset_o / proc_reset_o registered resets,
//        soft_reset_ack_o one-cycle ack on return to RUN, drain_timeout_o sticky drain timeout, state_o debug state.
module bsg_manycore_tile_reset_seq
   import bsg_manycore_reset_seq_pkg::*;
#(
   parameter int reset_hold_cycles_p    = 4,
   parameter int router_settle_cycles_p = 2,
   parameter int drain_timeout_p        = 256
) (
   input  logic                      clk_i,
   input  logic                      reset_i,
   input  logic                      soft_reset_req_i,
   input  logic                      link_idle_i,
   output logic                      router_reset_o,
   output logic                      proc_reset_o,
   output logic                      soft_reset_ack_o,
   output logic                      drain_timeout_o,
   output logic [state_width_lp-1:0] state_o
);
   localparam int max_a_lp = reset_hold_cycles_p > router_settle_cycles_p ? reset_hold_cycles_p : router_settle_cycles_p;
   localparam int max_lp = max_a_lp > drain_timeout_p ? max_a_lp : drain_timeout_p;
   localparam int ctr_width_lp = safe_clog2(max_lp + 1);
   state_e state, state_n;
   logic [ctr_width_lp-1:0] count;
   logic hold_done, settle_done, drain_done;
   logic router_reset_n, proc_reset_n, ack_n, timeout_n;
   assign hold_done   = count == ctr_width_lp'(reset_hold_cycles_p - 1);
   assign settle_done = count == ctr_width_lp'(router_settle_cycles_p - 1);
   assign drain_done  = count == ctr_width_lp'(drain_timeout_p - 1);
   // Every state change restarts the shared count from zero.
   bsg_counter_clear_up #(.width_p(ctr_width_lp)) ctr (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .clear_i (state_n != state),
      .up_i    (1'b1),
      .count_o (count)
   );
   always_ff @(posedge clk_i or posedge reset_i)
      if (reset_i) begin
         state            <= HOLD;
         router_reset_o   <= 1'b1;
         proc_reset_o     <= 1'b1;
         soft_reset_ack_o <= 1'b0;
         drain_timeout_o  <= 1'b0;
      end else begin
         state            <= state_n;
         router_reset_o   <= router_reset_n;
         proc_reset_o     <= proc_reset_n;
         soft_reset_ack_o <= ack_n;
         drain_timeout_o  <= timeout_n;
      end
   always_comb begin
      state_n = HOLD;
      case (state)
         HOLD:        state_n = hold_done ? RTR_UP : HOLD;
         RTR_UP:      state_n = settle_done ? RUN : RTR_UP;
         RUN:         state_n = soft_reset_req_i ? DRAIN : RUN;
         DRAIN:       state_n = (link_idle_i || drain_done) ? SOFT_RST : DRAIN;
         SOFT_RST:    state_n = hold_done ? SOFT_SETTLE : SOFT_RST;
         SOFT_SETTLE: state_n = settle_done ? RUN : SOFT_SETTLE;
         default:     state_n = HOLD;
      endcase
   end
   // Outputs are registered from the next state so they line up with state_o.
   always_comb begin
      router_reset_n = state_n == HOLD;
      proc_reset_n   = !(state_n == RUN || state_n == DRAIN);
      ack_n          = state == SOFT_SETTLE && state_n == RUN;
      // A link going idle on the terminal count is a clean drain, not a timeout.
      timeout_n      = drain_timeout_o | (state == DRAIN && !link_idle_i && drain_done);
   end
   assign state_o = state;
endmodule

// File: tb/tb_bsg_manycore_tile_reset_seq.sv
// tb_bsg_manycore_tile_reset_seq: directed scoreboard bench for the tile reset sequencer.
module tb_bsg_manycore_tile_reset_seq;
   import bsg_manycore_reset_seq_pkg::*;
   typedef struct {
      string      name;
      logic [6:0] v;
   } exp_t;
   logic clk_i = 1'b0;
   logic reset_i, soft_reset_req_i, link_idle_i;
   logic router_reset_o, proc_reset_o, soft_reset_ack_o, drain_timeout_o;
   logic [2:0] state_o;
   exp_t exp_q[$];
   exp_t cur;
   logic [6:0] got;
   int n_chk = 0;
   int n_fail = 0;
   event async_ev;

   bsg_manycore_tile_reset_seq dut (
      .clk_i            (clk_i),
      .reset_i          (reset_i),
      .soft_reset_req_i (soft_reset_req_i),
      .link_idle_i      (link_idle_i),
      .router_reset_o   (router_reset_o),
      .proc_reset_o     (proc_reset_o),
      .soft_reset_ack_o (soft_reset_ack_o),
      .drain_timeout_o  (drain_timeout_o),
      .state_o          (state_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic push(input string nm, input logic [2:0] st, input logic rr, pr, ack, to);
      exp_t e;
      e.name = nm;
      e.v = {st, rr, pr, ack, to};
      exp_q.push_back(e);
   endtask

   // Drive inputs for n cycles; after each edge queue the outputs that edge must produce.
   task automatic step(input string nm, input logic req, idle, input logic [2:0] st,
                       input logic rr, pr, ack, to, input int n);
      soft_reset_req_i = req;
      link_idle_i = idle;
      repeat (n) begin
         @(posedge clk_i);
         push(nm, st, rr, pr, ack, to);
         #1;
      end
   endtask

   task automatic async_chk(input string nm);
      push(nm, HOLD, 1'b1, 1'b1, 1'b0, 1'b0);
      -> async_ev;
   endtask

   task automatic powerup(input string nm);
      step({nm, "_hold"}, 1'b0, 1'b1, HOLD, 1'b1, 1'b1, 1'b0, 1'b0, 3);
      step({nm, "_rtr"}, 1'b0, 1'b1, RTR_UP, 1'b0, 1'b1, 1'b0, 1'b0, 2);
      step({nm, "_run"}, 1'b0, 1'b1, RUN, 1'b0, 1'b0, 1'b0, 1'b0, 2);
   endtask

   task automatic soft_tail(input string nm, input logic req, idle, to);
      step({nm, "_srst"}, req, idle, SOFT_RST, 1'b0, 1'b1, 1'b0, to, 4);
      step({nm, "_settle"}, req, idle, SOFT_SETTLE, 1'b0, 1'b1, 1'b0, to, 2);
      step({nm, "_ack"}, req, idle, RUN, 1'b0, 1'b0, 1'b1, to, 1);
      step({nm, "_after"}, req, idle, req ? DRAIN : RUN, 1'b0, 1'b0, 1'b0, to, 1);
   endtask

   initial begin
      forever begin
         @(negedge clk_i or async_ev);
         if (exp_q.size() != 0) begin
            cur = exp_q.pop_front();
            got = {state_o, router_reset_o, proc_reset_o, soft_reset_ack_o, drain_timeout_o};
            n_chk++;
            if (got !== cur.v) begin
               n_fail++;
               $display("FAIL %s: got {state,rr,pr,ack,to}=%b_%b%b%b%b expected %b_%b%b%b%b", cur.name,
                        got[6:4], got[3], got[2], got[1], got[0],
                        cur.v[6:4], cur.v[3], cur.v[2], cur.v[1], cur.v[0]);
            end
         end
      end
   end

   initial begin
      #100000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached with %0d expectations pending", exp_q.size());
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      reset_i = 1'b1;
      soft_reset_req_i = 1'b0;
      link_idle_i = 1'b1;
      #2;
      async_chk("reset_state");
      step("rst_held", 1'b0, 1'b1, HOLD, 1'b1, 1'b1, 1'b0, 1'b0, 3);
      reset_i = 1'b0;
      powerup("pwr");
      step("sr_req", 1'b1, 1'b1, DRAIN, 1'b0, 1'b0, 1'b0, 1'b0, 1);
      soft_tail("sr_idle", 1'b0, 1'b1, 1'b0);
      step("dw_req", 1'b1, 1'b0, DRAIN, 1'b0, 1'b0, 1'b0, 1'b0, 1);
      step("dw_wait", 1'b0, 1'b0, DRAIN, 1'b0, 1'b0, 1'b0, 1'b0, 10);
      soft_tail("dw", 1'b0, 1'b1, 1'b0);
      step("tie_req", 1'b1, 1'b0, DRAIN, 1'b0, 1'b0, 1'b0, 1'b0, 1);
      step("tie_wait", 1'b0, 1'b0, DRAIN, 1'b0, 1'b0, 1'b0, 1'b0, 255);
      soft_tail("tie", 1'b0, 1'b1, 1'b0);
      step("held_req", 1'b1, 1'b1, DRAIN, 1'b0, 1'b0, 1'b0, 1'b0, 1);
      soft_tail("held", 1'b1, 1'b1, 1'b0);
      soft_tail("b2b", 1'b0, 1'b1, 1'b0);
      step("to_req", 1'b1, 1'b0, DRAIN, 1'b0, 1'b0, 1'b0, 1'b0, 1);
      step("to_wait", 1'b0, 1'b0, DRAIN, 1'b0, 1'b0, 1'b0, 1'b0, 255);
      soft_tail("to", 1'b0, 1'b0, 1'b1);
      step("sticky_req", 1'b1, 1'b1, DRAIN, 1'b0, 1'b0, 1'b0, 1'b1, 1);
      soft_tail("sticky", 1'b0, 1'b1, 1'b1);
      step("mid_req", 1'b1, 1'b1, DRAIN, 1'b0, 1'b0, 1'b0, 1'b1, 1);
      step("mid_srst", 1'b0, 1'b1, SOFT_RST, 1'b0, 1'b1, 1'b0, 1'b1, 2);
      @(negedge clk_i);
      #1;
      reset_i = 1'b1;
      #1;
      async_chk("async_rst");
      step("mid_held", 1'b0, 1'b1, HOLD, 1'b1, 1'b1, 1'b0, 1'b0, 2);
      reset_i = 1'b0;
      powerup("repwr");
      #10;
      n_chk++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d unchecked expectations, expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/bsg_manycore_tile_reset_seq.md
Name: bsg_manycore_tile_reset_seq

Overview:
Per-tile reset and bring-up sequencer. It sits between the tile's reset input and the router and processor socket. It releases the mesh router before the processor so the router is ready before the core injects traffic. At run time it services a soft-reset request for the processor only: it first drains the processor link, then pulses the processor reset, and leaves the router running.

Parameters:
reset_hold_cycles_p, 4, cycles both resets stay asserted after reset_i deasserts; also the soft-reset pulse length; must be >=1
router_settle_cycles_p, 2, cycles between router reset release and proc reset release; must be >=1
drain_timeout_p, 256, max cycles spent waiting for link idle before forcing the soft reset; must be >=1
ctr_width_lp, derived, `BSG_SAFE_CLOG2 of (max of the three above)+1

Ports:
clk_i  input  1  tile clock
reset_i  input  1  asynchronous, active-high reset
soft_reset_req_i  input  1  level request for a processor-only reset; sampled only in RUN
link_idle_i  input  1  1 = no outstanding requests or credits on the processor link
router_reset_o  output  1  reset to the mesh router, registered
proc_reset_o  output  1  reset to the processor socket, registered
soft_reset_ack_o  output  1  one-cycle pulse when the soft-reset sequence returns to RUN
drain_timeout_o  output  1  sticky flag; set when a drain timed out; cleared only by reset_i
state_o  output  3  current state encoding, for debug

Behaviour:
- All outputs come from flops. Under reset_i (asynchronous):
  - router_reset_o=1, proc_reset_o=1
  - soft_reset_ack_o=0, drain_timeout_o=0
  - state=HOLD, counter=0
- Reset deassertion is seen at the first clk_i edge after reset_i falls.
- States:
  - HOLD: both resets = 1. Counter increments each cycle. When counter==reset_hold_cycles_p-1, go to RTR_UP, clear counter, drive router_reset_o=0 from the next cycle.
  - RTR_UP: router_reset_o=0, proc_reset_o=1. When counter==router_settle_cycles_p-1, go to RUN and set proc_reset_o=0.
  - RUN: both resets = 0. If soft_reset_req_i=1, go to DRAIN and clear counter.
  - DRAIN: resets unchanged. If link_idle_i=1, go to SOFT_RST.
    - Otherwise, when counter==drain_timeout_p-1, set drain_timeout_o and go to SOFT_RST.
    - If link_idle_i=1 in the same cycle as the timeout terminal count, idle wins and drain_timeout_o is not set.
  - SOFT_RST: proc_reset_o=1 for exactly reset_hold_cycles_p cycles, then go to SOFT_SETTLE.
  - SOFT_SETTLE: proc_reset_o=1 for router_settle_cycles_p cycles, then go to RUN. Deassert proc_reset_o and pulse soft_reset_ack_o in the first RUN cycle.
- Latency from reset_i deassert to proc_reset_o=0: reset_hold_cycles_p+router_settle_cycles_p cycles (4+2=6 with defaults).
- Router reset is never reasserted except by reset_i.
- soft_reset_req_i is ignored outside RUN.
- If soft_reset_req_i is still high on the ack cycle, a new DRAIN starts on the next cycle. The requester must drop the request on ack.
- reset_i asserted mid-sequence returns to HOLD immediately, both resets=1, and clears drain_timeout_o.
- The counter saturates; it never wraps. It is cleared on every state change.
- Encoding: HOLD=0, RTR_UP=1, RUN=2, DRAIN=3, SOFT_RST=4, SOFT_SETTLE=5. Encodings 6-7 are illegal; on reaching one, go to HOLD.

Decomposition:
- Shared package bsg_manycore_reset_seq_pkg: state enum typedef (3 bits, values above) and the state_o width constant.
- One sub-module: the existing bsg_counter_clear_up instance for the shared cycle counter, with clear driven by the FSM on each state transition.
- The FSM and output flops live in the top module.

Test Plan:
- Power-up: reset_i high for 3 cycles, then low, defaults -> router_reset_o falls at cycle 4 after release; proc_reset_o falls at cycle 6; state_o=2; ack=0.
- Soft reset, idle link: in RUN, soft_reset_req_i=1 for one cycle, link_idle_i=1 -> DRAIN 1 cycle; proc_reset_o=1 for 4+2 cycles; router_reset_o stays 0; ack pulses once; timeout=0.
- Drain wait: request with link_idle_i=0 for 10 cycles, then 1 -> SOFT_RST entered on cycle 11 of DRAIN; drain_timeout_o=0.
- Drain timeout: link_idle_i held 0 -> after 256 DRAIN cycles, drain_timeout_o=1 (sticky through a second soft reset) and the soft reset proceeds.
- Tie case: link_idle_i rises exactly on DRAIN count 255 -> drain_timeout_o stays 0.
- Async reset mid-SOFT_RST: assert reset_i between edges -> both resets=1 and drain_timeout_o=0 with no clock edge; full power-up sequence then repeats.
